i2c_slave_rx: RTL and testbench

// I2C target-side receiver. It sits directly downstream of the I2C master that drives the bus.
// It watches SCL/SDA, detects START, repeated START and STOP, and matches the 7-bit address.
// It ACKs each byte and packs write-data bytes MSB-first into words of BYTES_PER_WORD bytes.

---
 rtl/i2c_slave_rx.sv | 109 ++++++++++
 tb/tb_i2c_slave_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: I2C write-only target receiver packing ACKed data bytes into valid/ready words.
module i2c_slave_rx #(
  parameter int BYTES_PER_WORD = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  input  logic [6:0]  own_address,
  input  logic        rx_ready,
  output logic        sda_oe,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        rx_err
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
  localparam logic [31:0] MASK = 32'hffff_ffff >> (32 - 8 * BYTES_PER_WORD);
  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
  logic [SYNC_STAGES-1:0] scl_s, sda_s;
  logic scl_d, sda_d, scl, sda, scl_rise, scl_fall, start, stop, last;
  state_t state;
  logic [3:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] shift;
  logic [31:0] acc;
  assign scl = scl_s[SYNC_STAGES-1];
  assign sda = sda_s[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start = scl & scl_d & sda_d & ~sda;
  assign stop = scl & scl_d & ~sda_d & sda;
  assign last = byte_cnt == LAST;
  // Synchronisers reset to the idle-bus level so release never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= IDLE;
      bit_cnt <= 4'd0;
      byte_cnt <= 2'd0;
      shift <= 8'd0;
      acc <= 32'd0;
      sda_oe <= 1'b0;
      rx_data <= 32'd0;
      rx_valid <= 1'b0;
      rx_busy <= 1'b0;
      rx_err <= 1'b0;
    end else begin
      scl_s <= {scl_s[SYNC_STAGES-2:0], scl_in};
      sda_s <= {sda_s[SYNC_STAGES-2:0], sda_in};
      scl_d <= scl;
      sda_d <= sda;
      rx_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (start || stop) begin
        state <= start ? ADDR : IDLE;
        bit_cnt <= 4'd0;
        byte_cnt <= 2'd0;
        sda_oe <= 1'b0;
        rx_busy <= 1'b0;
        rx_err <= byte_cnt != 2'd0;
      end else if (scl_rise && (state == ADDR || state == DATA) && bit_cnt != 4'd8) begin
        shift <= {shift[6:0], sda};
        bit_cnt <= bit_cnt + 4'd1;
      end else if (scl_fall) begin
        case (state)
          ADDR: if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (shift[7:1] == own_address && !shift[0]) begin
              state <= ADDR_ACK;
              sda_oe <= 1'b1;
              rx_busy <= 1'b1;
            end else begin
              state <= IGNORE;
            end
          end
          ADDR_ACK, DATA_ACK: begin
            sda_oe <= 1'b0;
            bit_cnt <= 4'd0;
            state <= DATA;
          end
          DATA: if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            // A completing byte with the previous word still unread is refused.
            if (last && rx_valid) begin
              rx_err <= 1'b1;
              state <= IGNORE;
            end else begin
              sda_oe <= 1'b1;
              acc <= {acc[23:0], shift};
              byte_cnt <= last ? 2'd0 : byte_cnt + 2'd1;
              state <= DATA_ACK;
              if (last) begin
                rx_data <= {acc[23:0], shift} & MASK;
                rx_valid <= 1'b1;
              end
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: bit-banged I2C master driving directed and random write frames, checked against a byte-level model.
module tb_i2c_slave_rx;
  localparam int BPW = 4;
  localparam int Q = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic rx_ready = 1'b0;
  logic [6:0] own = 7'h01;
  logic sda_oe, rx_valid, rx_busy, rx_err, sda_bus;
  logic [31:0] rx_data;
  int n_chk, n_fail, err_cnt, err_exp, oe_cnt, base;
  logic [31:0] got_q[$], exp_q[$];
  logic [7:0] tx[$];
  bit pending;

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_slave_rx #(.BYTES_PER_WORD(BPW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus), .own_address(own),
    .rx_ready(rx_ready), .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_busy(rx_busy), .rx_err(rx_err)
  );

  always @(negedge clk) begin
    if (rx_err) err_cnt++;
    if (sda_oe) oe_cnt++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(Q);
      scl_m = 1'b1; tick(2 * Q);
      scl_m = 1'b0; tick(Q);
    end
  endtask

  task automatic ack_clock(output logic ack);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  // Model: an addressed write ACKs bytes until a word completes while the previous one is unread.
  task automatic run_frame(input logic [7:0] ab, input bit do_stop);
    bit match, ign;
    int cnt;
    logic ack;
    logic [31:0] wbuf;
    bus_start();
    match = (ab[7:1] == own) && !ab[0];
    send_bits(ab);
    ack_clock(ack);
    check("addr_ack", ack, match);
    check("busy_in_frame", rx_busy, match);
    ign = !match;
    cnt = 0;
    wbuf = 0;
    foreach (tx[i]) begin
      bit e_ack;
      e_ack = 0;
      if (!ign) begin
        if (cnt == BPW - 1 && pending) begin
          ign = 1;
          err_exp++;
        end else begin
          e_ack = 1;
          wbuf = {wbuf[23:0], tx[i]};
          cnt = (cnt + 1) % BPW;
          if (cnt == 0) begin
            exp_q.push_back(wbuf);
            pending = !rx_ready;
          end
        end
      end
      send_bits(tx[i]);
      ack_clock(ack);
      check($sformatf("data_ack[%0d]", i), ack, e_ack);
    end
    if (cnt != 0) err_exp++;
    if (do_stop) begin
      bus_stop();
      tick(4);
      check("busy_after_stop", rx_busy, 0);
      check("err_count", err_cnt, err_exp);
    end
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick(6);
    pending = 0;
    check("word_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("word[%0d]", i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2 reset = 1'b0;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_rx_err", rx_err, 0);
    reset = 1'b1;
    tick(4);

    rx_ready = 1'b0;
    tx = '{8'h00, 8'h00, 8'h00, 8'h07};
    run_frame(8'h02, 1);
    check("t1_valid_held", rx_valid, 1);
    check("t1_data", rx_data, 32'h0000_0007);
    drain();
    check("t1_valid_cleared", rx_valid, 0);

    base = oe_cnt;
    tx = '{8'hAA, 8'h55};
    run_frame(8'h04, 1);
    check("t2_oe_cycles", oe_cnt - base, 0);
    check("t2_valid", rx_valid, 0);
    drain();

    tx.delete();
    run_frame(8'h03, 1);

    rx_ready = 1'b0;
    tx = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h0F};
    run_frame(8'h02, 1);
    check("t4_data", rx_data, 32'h0000_0007);
    drain();

    tx = '{8'h12, 8'h34};
    run_frame(8'h02, 1);
    check("t5_no_valid", rx_valid, 0);
    tx = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(8'h02, 1);
    drain();

    tx = '{8'h09, 8'h09};
    run_frame(8'h02, 0);
    tx = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_frame(8'h02, 1);
    drain();

    bus_start();
    send_bits(8'h02);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(1);
    check("t6_oe_before_reset", sda_oe, 1);
    reset = 1'b0;
    #1;
    check("t6_oe_async_release", sda_oe, 0);
    tick(4);
    reset = 1'b1;
    tick(4);
    check("t6_sda_oe", sda_oe, 0);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_rx_busy", rx_busy, 0);
    check("t6_rx_data", rx_data, 0);
    pending = 0;
    got_q.delete();
    exp_q.delete();
    tx = '{8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(8'h02, 1);
    drain();

    for (int k = 0; k < 12; k++) begin
      int sel;
      logic [7:0] ab;
      own = 7'($urandom);
      sel = $urandom_range(0, 3);
      ab = sel < 2 ? {own, 1'b0} : sel == 2 ? {own, 1'b1} : 8'($urandom);
      rx_ready = $urandom_range(0, 3) != 0;
      tx.delete();
      for (int j = $urandom_range(0, 9); j > 0; j--) tx.push_back(8'($urandom));
      run_frame(ab, 1);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
